// File: rtl/adc_pkg.sv
// Shared ADC definitions: engine widths, scheduler state encoding, sensor channel map.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package adc_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_CH_W   = 3;

  // Line-sensor channel assignment on the ADC128S022 inputs
  localparam logic [ADC_CH_W-1:0] CH_LEFT   = 3'd0;
  localparam logic [ADC_CH_W-1:0] CH_CENTRE = 3'd1;
  localparam logic [ADC_CH_W-1:0] CH_RIGHT  = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping past N-1 to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the grant and advance ptr.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  // Walk the requests starting at ptr and stop at the first one found
  always_comb begin : pick
    int k;
    k         = 0;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any_req && req[k]) begin
        grant[k]  = 1'b1;
        grant_idx = IW'(k);
        any_req   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_req_scheduler.sv
// Shares one ADC frame engine between NREQ requesters, round-robin, one conversion at a time.
// Latency: conv_start 1 cycle after req seen idle; rsp_valid 1 cycle after conv_done or timeout.
// Backpressure: conv_busy holds the grant in ISSUE; requesters keep req high until their rsp_valid.
module adc_req_scheduler
  import adc_pkg::*;
#(
  parameter  int NREQ           = 4,
  parameter  int CH_W           = ADC_CH_W,
  parameter  int DATA_W         = ADC_DATA_W,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IW             = $clog2(NREQ)
) (
  input  logic                 clk_50,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CH_W-1:0] req_ch,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_err,
  output logic                 conv_start,
  output logic [CH_W-1:0]      conv_ch,
  input  logic                 conv_busy,
  input  logic                 conv_done,
  input  logic [DATA_W-1:0]    conv_data,
  output logic [IW-1:0]        grant_idx,
  output logic [7:0]           timeout_cnt
);

  localparam int             TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0]  LAST_IDX   = IW'(NREQ - 1);

  sched_state_t    state;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] grant_oh;
  logic [TW-1:0]   timer;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Start must react to conv_busy in the same cycle so it fires on the first idle-engine cycle
  assign conv_start = (state == ISSUE) && !conv_busy;

  // Scheduler FSM: grant, issue, wait for result or timeout, then pulse the response
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_oh    <= '0;
      grant_idx   <= '0;
      conv_ch     <= '0;
      timer       <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_idx <= arb_idx;
            grant_oh  <= arb_grant;
            conv_ch   <= req_ch[int'(arb_idx)*CH_W +: CH_W];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!conv_busy) begin
            timer <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          timer <= timer + TW'(1);
          // A result arriving on the last allowed cycle still beats the timeout
          if (conv_done) begin
            rsp_data  <= conv_data;
            rsp_err   <= 1'b0;
            rsp_valid <= grant_oh;
            state     <= RESPOND;
          end else if (timer == TIMER_LAST) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= grant_oh;
            if (timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
            state     <= RESPOND;
          end
        end
        RESPOND: begin
          rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
